// File: rtl/subtracter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : subtracter_arbiter_pkg
//  Purpose : Shared definitions for the subtracter arbiter: FSM state
//            encoding and the datapath word width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package subtracter_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/subtracter_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin picker. Returns the first asserted
//            request at or after ptr, wrapping modulo N_REQ.
//  Ports   : req       in  N_REQ   request vector
//            ptr       in  PTR_W   search start index
//            gnt_id    out PTR_W   winning index
//            gnt_valid out 1       any request asserted
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick
    import subtracter_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gnt_id,
    output logic             gnt_valid
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down to offset 0 so that the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                gnt_id    = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/subtracter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : subtracter_arbiter
//  Purpose : Shares one external 32-bit subtracter/comparator among N_REQ
//            requesters. Round-robin grant, registered operands, registered
//            result, one-cycle done pulse per requester.
//  Ports   : clock, resetn (sync, active low)
//            req[N_REQ], req_a/req_b[N_REQ*32]  requester side
//            sub_a/sub_b out, sub_s/sub_ovf/sub_ne/sub_lt in  subtracter side
//            done[N_REQ], res_diff/res_ne/res_lt/res_ovf    result side
//            busy, op_count[CNT_W]                          status
//  Rev     : 1.0  initial release
// ============================================================================
module subtracter_arbiter
    import subtracter_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   req_a,
    input  logic [N_REQ*WORD_W-1:0]   req_b,
    output logic [WORD_W-1:0]         sub_a,
    output logic [WORD_W-1:0]         sub_b,
    input  logic [WORD_W-1:0]         sub_s,
    input  logic                      sub_ovf,
    input  logic                      sub_ne,
    input  logic                      sub_lt,
    output logic [N_REQ-1:0]          done,
    output logic [WORD_W-1:0]         res_diff,
    output logic                      res_ne,
    output logic                      res_lt,
    output logic                      res_ovf,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_id;
    logic [PTR_W-1:0]   gnt_id;
    logic               gnt_valid;
    logic [N_REQ-1:0]   req_eff;
    logic [WORD_W-1:0]  a_sel, b_sel;

    // A requester whose done is high this cycle still shows req until the
    // coming edge; masking it keeps a served request from being re-granted.
    assign req_eff = req & ~done;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req       (req_eff),
        .ptr       (rr_ptr),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == PTR_W'(i)) begin
                a_sel = req_a[i*WORD_W +: WORD_W];
                b_sel = req_b[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (gnt_valid) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            win_id   <= '0;
            sub_a    <= '0;
            sub_b    <= '0;
            done     <= '0;
            res_diff <= '0;
            res_ne   <= 1'b0;
            res_lt   <= 1'b0;
            res_ovf  <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        sub_a  <= a_sel;
                        sub_b  <= b_sel;
                        win_id <= gnt_id;
                    end
                end
                ST_CAPTURE: begin
                    res_diff <= sub_s;
                    res_ne   <= sub_ne;
                    res_lt   <= sub_lt;
                    res_ovf  <= sub_ovf;
                    done     <= N_REQ'(1) << win_id;
                    rr_ptr   <= (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + PTR_W'(1);
                    op_count <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
